// File: rtl/countdown_timer_if.sv
// Signal bundle for countdown_timer.
// Control semantics (there is no valid/ready pair): start, abort and tick_en
// are level-sampled on every rising clock edge. A start is accepted only on
// an edge where the timer is in IDLE or DONE and abort is low. abort wins
// over start. tick_en only matters while RUN. The outputs come from registers
// (zero is decoded from the count register) and are valid one edge after the
// inputs that caused them.
// fsm_state exposes the registered FSM state (0 IDLE, 1 RUN, 2 DONE).
interface countdown_timer_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] load_val;
  logic             abort;
  logic             tick_en;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;
  logic             zero;
  logic [1:0]       fsm_state;

  modport master (
    output start, load_val, abort, tick_en,
    input  count, busy, done, zero, fsm_state
  );

  modport slave (
    input  start, load_val, abort, tick_en,
    output count, busy, done, zero, fsm_state
  );
endinterface

// File: rtl/countdown_timer.sv
// Loadable down-counter with a tick prescaler and a three-state FSM
// (IDLE, RUN, DONE). done pulses for the single DONE cycle that follows the
// count reaching zero.
// Optional feature: define COUNTDOWN_TIMER_AUTO_RELOAD_EN to make DONE reload
// the last started value and run again. In the default build DONE returns
// to IDLE and no reload register exists.
module countdown_timer #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 1
) (
  input logic              clock,
  input logic              res,
  countdown_timer_if.slave bus
);

  // Prescaler needs at least one bit even when PRESCALE is 1.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(PRESCALE - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [PW-1:0]    presc_q, presc_d;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] reload_q, reload_d;
`endif

  // State register; reset clears everything and overrides every other input.
  always_ff @(posedge clock) begin
    if (res) begin
      state_q  <= IDLE;
      count_q  <= '0;
      presc_q  <= '0;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      presc_q  <= presc_d;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  // Next-state logic: abort first, then start (IDLE/DONE only), then ticks.
  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    presc_d  = presc_q;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    if (bus.abort) begin
      state_d = IDLE;
      count_d = '0;
      presc_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start) begin
            count_d  = bus.load_val;
            presc_d  = '0;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
            reload_d = bus.load_val;
`endif
            state_d  = (bus.load_val == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          // start is deliberately ignored here; only ticks matter.
          if (bus.tick_en) begin
            if (presc_q == PRESC_MAX) begin
              presc_d = '0;
              // Guard keeps the count from ever wrapping below zero.
              if (count_q != '0) begin
                count_d = count_q - 1'b1;
              end
              if (count_q <= WIDTH'(1)) begin
                state_d = DONE;
              end
            end else begin
              presc_d = presc_q + 1'b1;
            end
          end
        end
        DONE: begin
          if (bus.start) begin
            count_d  = bus.load_val;
            presc_d  = '0;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
            reload_d = bus.load_val;
`endif
            state_d  = (bus.load_val == '0) ? DONE : RUN;
          end else begin
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
            // A zero reload value parks in DONE with done held high.
            count_d = reload_q;
            presc_d = '0;
            state_d = (reload_q == '0) ? DONE : RUN;
`else
            state_d = IDLE;
`endif
          end
        end
        default: begin
          state_d = IDLE;
          count_d = '0;
          presc_d = '0;
        end
      endcase
    end
  end

  // Output decode from registered state and count only.
  always_comb begin
    bus.count     = count_q;
    bus.busy      = (state_q == RUN);
    bus.done      = (state_q == DONE);
    bus.zero      = (count_q == '0);
    bus.fsm_state = state_q;
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: one instance with PRESCALE=1, one with
// PRESCALE=4, both fed identical stimulus. A reference model pushes the
// expected {busy,done,zero,count} word per cycle; directed scenarios add
// hand-derived checks. Define COUNTDOWN_TIMER_AUTO_RELOAD_EN for both RTL
// and bench to exercise the auto-reload build.
module tb_countdown_timer;

  logic clock;
  logic res;

  countdown_timer_if #(.WIDTH(4)) b1 ();
  countdown_timer_if #(.WIDTH(4)) b4 ();

  countdown_timer #(.WIDTH(4), .PRESCALE(1)) u1 (
    .clock (clock),
    .res   (res),
    .bus   (b1.slave)
  );

  countdown_timer #(.WIDTH(4), .PRESCALE(4)) u4 (
    .clock (clock),
    .res   (res),
    .bus   (b4.slave)
  );

  // Clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: st 0 IDLE, 1 RUN, 2 DONE
  typedef struct {
    int         st;
    logic [3:0] cnt;
    int         pre;
    logic [3:0] rel;
  } mdl_t;

  function automatic mdl_t mdl_step(input mdl_t m, input int prescale, input logic r,
                                    input logic s, input logic [3:0] lv, input logic a,
                                    input logic t);
    mdl_t n = m;
    if (r) begin
      n.st = 0; n.cnt = 0; n.pre = 0; n.rel = 0;
    end else if (a) begin
      n.st = 0; n.cnt = 0; n.pre = 0;
    end else if ((m.st == 0 || m.st == 2) && s) begin
      n.cnt = lv; n.pre = 0; n.rel = lv;
      n.st  = (lv == 0) ? 2 : 1;
    end else if (m.st == 1) begin
      if (t) begin
        if (m.pre == prescale - 1) begin
          n.pre = 0;
          n.cnt = m.cnt - 4'd1;
          if (n.cnt == 0) n.st = 2;
        end else begin
          n.pre = m.pre + 1;
        end
      end
    end else if (m.st == 2) begin
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
      n.cnt = m.rel; n.pre = 0;
      n.st  = (m.rel == 0) ? 2 : 1;
`else
      n.st = 0;
`endif
    end
    return n;
  endfunction

  function automatic logic [6:0] mdl_out(input mdl_t m);
    return {m.st == 1, m.st == 2, m.cnt == 4'd0, m.cnt};
  endfunction

  // Scoreboard
  logic [6:0] exp1_q[$];
  logic [6:0] exp4_q[$];
  mdl_t m1, m4;
  logic [6:0] o1, o4;

  // Driver: apply one cycle of inputs to both instances, compare after the edge.
  task automatic cycle(input logic r, input logic s, input logic [3:0] lv,
                       input logic a, input logic t);
    res = r;
    b1.start = s; b1.load_val = lv; b1.abort = a; b1.tick_en = t;
    b4.start = s; b4.load_val = lv; b4.abort = a; b4.tick_en = t;
    m1 = mdl_step(m1, 1, r, s, lv, a, t);
    m4 = mdl_step(m4, 4, r, s, lv, a, t);
    exp1_q.push_back(mdl_out(m1));
    exp4_q.push_back(mdl_out(m4));
    @(posedge clock);
    #1;
    o1 = {b1.busy, b1.done, b1.zero, b1.count};
    o4 = {b4.busy, b4.done, b4.zero, b4.count};
    check_eq("sb_p1", o1, exp1_q.pop_front());
    check_eq("sb_p4", o4, exp4_q.pop_front());
  endtask

  int busy_n, done_n, first_done, held2;
  logic [3:0] seq [0:5];

  initial begin
    m1 = '{st: 0, cnt: 0, pre: 0, rel: 0};
    m4 = '{st: 0, cnt: 0, pre: 0, rel: 0};
    res = 1'b1;
    b1.start = 0; b1.load_val = 0; b1.abort = 0; b1.tick_en = 0;
    b4.start = 0; b4.load_val = 0; b4.abort = 0; b4.tick_en = 0;
    @(negedge clock);

    // Reset, with other inputs active (must be ignored)
    cycle(1, 1, 4'd7, 0, 1);
    check_eq("rst_p1", o1, 7'b001_0000);
    check_eq("rst_p4", o4, 7'b001_0000);

    // Basic countdown from 3
    cycle(0, 0, 0, 1, 1);
    cycle(0, 1, 4'd3, 0, 1);
    check_eq("c3_load", o1[3:0], 4'd3);
    busy_n = o1[6]; done_n = o1[5];
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, 1);
      check_eq("c3_seq", o1[3:0], 32'(2 - i));
      busy_n += o1[6]; done_n += o1[5];
    end
    check_eq("c3_done_at0", o1[5], 1);
    check_eq("c3_busy_n", busy_n, 3);
    check_eq("c3_done_n", done_n, 1);
    cycle(0, 0, 0, 0, 1);
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
    check_eq("c3_reload", o1[3:0], 4'd3);
`else
    check_eq("c3_done_off", o1[5], 0);
    check_eq("c3_idle_cnt", o1[3:0], 0);
`endif

    // Prescale of 4 on u4
    cycle(0, 0, 0, 1, 1);
    cycle(0, 1, 4'd2, 0, 1);
    check_eq("p4_load", o4[3:0], 4'd2);
    held2 = 1; first_done = 0;
    for (int i = 1; i <= 8; i++) begin
      cycle(0, 0, 0, 0, 1);
      if (o4[3:0] == 4'd2) held2++;
      if (o4[5] && first_done == 0) first_done = i;
    end
    check_eq("p4_held2", held2, 4);
    check_eq("p4_done_at", first_done, 8);

    // Abort at count 3, with a simultaneous start
    cycle(0, 0, 0, 1, 1);
    cycle(0, 1, 4'd5, 0, 1);
    done_n = o1[5];
    cycle(0, 0, 0, 0, 1);
    done_n += o1[5];
    cycle(0, 0, 0, 0, 1);
    done_n += o1[5];
    check_eq("ab_cnt3", o1[3:0], 4'd3);
    cycle(0, 1, 4'd7, 1, 1);
    done_n += o1[5];
    check_eq("ab_cnt0", o1[3:0], 0);
    check_eq("ab_busy", o1[6], 0);
    check_eq("ab_state", b1.fsm_state, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, 1);
      done_n += o1[5];
    end
    check_eq("ab_no_done", done_n, 0);

    // Zero load
    cycle(0, 1, 4'd0, 0, 1);
    check_eq("z_busy", o1[6], 0);
    check_eq("z_done", o1[5], 1);
    check_eq("z_zero", o1[4], 1);
    cycle(0, 0, 0, 0, 1);
    check_eq("z_zero2", o1[4], 1);
    check_eq("z_busy2", o1[6], 0);
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
    check_eq("z_done_held", o1[5], 1);
`else
    check_eq("z_done_off", o1[5], 0);
`endif

    // Ignored start in RUN, tick gating, then reset at count 6
    cycle(0, 0, 0, 1, 1);
    cycle(0, 1, 4'd9, 0, 1);
    cycle(0, 0, 0, 0, 1);
    check_eq("tg_8", o1[3:0], 4'd8);
    cycle(0, 1, 4'd2, 0, 0);
    check_eq("tg_start_ign", o1[3:0], 4'd8);
    check_eq("tg_busy", o1[6], 1);
    cycle(0, 0, 0, 0, 1);
    check_eq("tg_7", o1[3:0], 4'd7);
    cycle(0, 0, 0, 0, 0);
    check_eq("tg_hold7", o1[3:0], 4'd7);
    cycle(0, 0, 0, 0, 1);
    check_eq("tg_6", o1[3:0], 4'd6);
    cycle(1, 1, 4'd3, 0, 1);
    check_eq("rr_cnt", o1[3:0], 0);
    check_eq("rr_busy", o1[6], 0);
    check_eq("rr_done", o1[5], 0);
    cycle(0, 0, 0, 0, 1);
    check_eq("rr_done2", o1[5], 0);

    // Reload behaviour after a count of 2
    cycle(0, 0, 0, 1, 1);
    cycle(0, 1, 4'd2, 0, 1);
    check_eq("rl_2", o1[3:0], 4'd2);
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
    seq[0] = 1; seq[1] = 0; seq[2] = 2; seq[3] = 1; seq[4] = 0; seq[5] = 2;
    for (int i = 0; i < 6; i++) begin
      cycle(0, 0, 0, 0, 1);
      check_eq("rl_seq", o1[3:0], seq[i]);
      check_eq("rl_done", o1[5], (seq[i] == 0));
    end
    cycle(0, 0, 0, 1, 1);
    check_eq("rl_abort_cnt", o1[3:0], 0);
    check_eq("rl_abort_done", o1[5], 0);
`else
    cycle(0, 0, 0, 0, 1);
    cycle(0, 0, 0, 0, 1);
    check_eq("nr_done", o1[5], 1);
    cycle(0, 0, 0, 0, 1);
    check_eq("nr_idle", b1.fsm_state, 0);
    check_eq("nr_cnt", o1[3:0], 0);
`endif

    // Random stimulus against the model
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 59) == 0, $urandom_range(0, 5) == 0,
            4'($urandom_range(0, 15)), $urandom_range(0, 29) == 0,
            $urandom_range(0, 3) != 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
